ram_access: RTL

Load/store adapter sitting directly upstream of port A of the byte-enabled dual-port block RAM. It turns byte-addressed byte/half/word reads and writes from the core into word-addressed RAM accesses with byte-lane write enables. Accesses that straddle a word boundary become two back-to-back RAM cycles. Read data is sign- or zero-extended.

---
 rtl/ram_access_pkg.sv | 20 ++
 rtl/ram_access_extract.sv | 22 ++
 rtl/ram_access.sv | 119 +++++++++++
 3 files changed

// File: rtl/ram_access_pkg.sv
// ram_access_pkg: shared access-width and state encodings for the load/store adapter
package ram_access_pkg;

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_BYTE = 2'b01;
    localparam logic [1:0] TYPE_HALF = 2'b10;
    localparam logic [1:0] TYPE_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE_HI  = 2'd1,
        READ_LO   = 2'd2,
        READ_LAST = 2'd3
    } state_t;

    function automatic logic [2:0] type_size(input logic [1:0] t);
        return (t == TYPE_BYTE) ? 3'd1 : (t == TYPE_HALF) ? 3'd2 : (t == TYPE_WORD) ? 3'd4 : 3'd0;
    endfunction

endpackage

// File: rtl/ram_access_extract.sv
// ram_access_extract: pulls the addressed bytes out of a two-word window and extends them
module ram_access_extract
    import ram_access_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // align the addressed bytes to bit 0, then truncate to the access width and extend
    always_comb begin
        shifted = 32'(raw >> {offset, 3'b000});
        result  = (size == type_size(TYPE_BYTE)) ? {{24{sign & shifted[7]}}, shifted[7:0]}
                : (size == type_size(TYPE_HALF)) ? {{16{sign & shifted[15]}}, shifted[15:0]}
                : shifted;
    end

endmodule

// File: rtl/ram_access.sv
// ram_access: byte-addressed load/store adapter in front of a word-wide byte-enabled RAM port
module ram_access
    import ram_access_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH = 16,
    parameter int DATA_BITWIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [ADDRESS_BITWIDTH-1:0] address,
    input  logic [1:0]                  write_type,
    input  logic [2:0]                  read_type,
    input  logic [DATA_BITWIDTH-1:0]    data_in,
    output logic [DATA_BITWIDTH-1:0]    data_out,
    output logic                        data_ready,
    output logic                        busy,
    output logic [ADDRESS_BITWIDTH-3:0] ram_address,
    output logic [3:0]                  ram_write_enable,
    output logic [DATA_BITWIDTH-1:0]    ram_data_in,
    input  logic [DATA_BITWIDTH-1:0]    ram_data_out
);

    localparam int WW = ADDRESS_BITWIDTH - 2;

    state_t        state, state_next;
    logic [WW-1:0] word_reg, word_next;
    logic [1:0]    offset_reg;
    logic [2:0]    size_reg;
    logic          sign_reg;
    logic [3:0]    hi_mask_reg;
    logic [31:0]   hi_data_reg, lo_reg, result;
    logic          is_write, accept, split, last_split;
    logic [1:0]    req_type;
    logic [2:0]    req_size;
    logic [7:0]    mask8;
    logic [63:0]   data64, raw;

    assign is_write   = write_type != TYPE_NONE;
    assign req_type   = is_write ? write_type : read_type[1:0];
    assign req_size   = type_size(req_type);
    assign accept     = enable && state == IDLE && req_type != TYPE_NONE;
    assign split      = ({1'b0, address[1:0]} + req_size) > 3'd4;
    assign mask8      = {4'b0000, (req_size == 3'd1) ? 4'b0001 : (req_size == 3'd2) ? 4'b0011 : 4'b1111} << address[1:0];
    assign data64     = {32'b0, data_in} << {address[1:0], 3'b000};
    assign word_next  = word_reg + WW'(1);
    assign last_split = ({1'b0, offset_reg} + size_reg) > 3'd4;
    assign raw        = last_split ? {ram_data_out, lo_reg} : {32'b0, ram_data_out};

    ram_access_extract u_extract (
        .raw    (raw),
        .offset (offset_reg),
        .size   (size_reg),
        .sign   (sign_reg),
        .result (result)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_next;

    // next state and RAM port drive; IDLE forwards the request so the RAM captures at acceptance
    always_comb begin
        state_next       = state;
        busy             = state != IDLE;
        ram_address      = word_reg;
        ram_write_enable = 4'b0000;
        ram_data_in      = '0;
        case (state)
            IDLE: begin
                ram_address      = address[ADDRESS_BITWIDTH-1:2];
                ram_write_enable = (accept && is_write) ? mask8[3:0] : 4'b0000;
                ram_data_in      = data64[31:0];
                state_next       = !accept ? IDLE
                                 : is_write ? (split ? WRITE_HI : IDLE)
                                 : (split ? READ_LO : READ_LAST);
            end
            WRITE_HI: begin
                ram_address      = word_next;
                ram_write_enable = hi_mask_reg;
                ram_data_in      = hi_data_reg;
                state_next       = IDLE;
            end
            READ_LO: begin
                ram_address = word_next;
                state_next  = READ_LAST;
            end
            default: state_next = IDLE;
        endcase
    end

    // latch the accepted request, collect the low read word, and register the load result
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            word_reg    <= '0;
            offset_reg  <= '0;
            size_reg    <= '0;
            sign_reg    <= 1'b0;
            hi_mask_reg <= '0;
            hi_data_reg <= '0;
            lo_reg      <= '0;
            data_out    <= '0;
            data_ready  <= 1'b0;
        end else begin
            data_ready <= state == READ_LAST;
            if (accept) begin
                word_reg    <= address[ADDRESS_BITWIDTH-1:2];
                offset_reg  <= address[1:0];
                size_reg    <= req_size;
                sign_reg    <= read_type[2];
                hi_mask_reg <= mask8[7:4];
                hi_data_reg <= data64[63:32];
            end
            if (state == READ_LO)   lo_reg   <= ram_data_out;
            if (state == READ_LAST) data_out <= result;
        end

endmodule
